rx_desc_gen: RTL and testbench

RX_DESC_GEN -- requirements
Module: rx_desc_gen

---
 rtl/i3c_pkg.sv | 25 ++
 rtl/rx_desc_gen_if.sv | 28 ++
 rtl/rx_desc_gen.sv | 104 ++++++++++
 tb/tb_rx_desc_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/i3c_pkg.sv
// rtl/i3c_pkg.sv - RX descriptor layout shared between the descriptor generator and the TTI queue side
package i3c_pkg;

    localparam int DESC_W       = 32;
    localparam int DESC_OVF_BIT = 31;
    localparam int DESC_LEN_LSB = 0;
    localparam int DESC_LEN_W   = 16;

    typedef struct packed {
        logic                                 ovf;
        logic [DESC_OVF_BIT-DESC_LEN_W-1:0]   reserved;
        logic [DESC_LEN_W-1:0]                len;
    } rx_desc_t;

    // Length is zero-extended by the caller; unused upper bits stay reserved-zero.
    function automatic logic [DESC_W-1:0] rx_desc_pack(input logic ovf,
                                                       input logic [DESC_OVF_BIT-1:0] len);
        logic [DESC_W-1:0] d;
        d                   = '0;
        d[DESC_OVF_BIT-1:0] = len;
        d[DESC_OVF_BIT]     = ovf;
        return d;
    endfunction

endpackage

// File: rtl/rx_desc_gen_if.sv
// rtl/rx_desc_gen_if.sv - received byte stream, packer byte stream, flush and descriptor signals
interface rx_desc_gen_if;

    logic                        in_valid_i;
    logic                        in_ready_o;
    logic [7:0]                  in_data_i;
    logic                        in_last_i;

    logic                        byte_valid_o;
    logic                        byte_ready_i;
    logic [7:0]                  byte_data_o;
    logic                        flush_o;

    logic                        desc_valid_o;
    logic                        desc_ready_i;
    logic [i3c_pkg::DESC_W-1:0]  desc_data_o;

    modport master (
        input  in_valid_i, in_data_i, in_last_i, byte_ready_i, desc_ready_i,
        output in_ready_o, byte_valid_o, byte_data_o, flush_o, desc_valid_o, desc_data_o
    );

    modport slave (
        output in_valid_i, in_data_i, in_last_i, byte_ready_i, desc_ready_i,
        input  in_ready_o, byte_valid_o, byte_data_o, flush_o, desc_valid_o, desc_data_o
    );

endinterface

// File: rtl/rx_desc_gen.sv
// rtl/rx_desc_gen.sv - passes RX bytes to the packer, flushes partial words, emits length descriptors
// Optional: RX_DESC_OVF_EN saturates the length and reports overflow in bit 31.
module rx_desc_gen
    import i3c_pkg::*;
#(
    parameter int Width    = 32,
    parameter int LenWidth = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    rx_desc_gen_if.master  bus
);

    localparam int BytesPerWord = Width / 8;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        FLUSH,
        DESC
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [LenWidth-1:0]   r_len;
    logic [LenWidth-1:0]   w_len_inc;
    logic                  w_ovf;
    logic                  w_pass;
    logic                  w_accept;
    logic                  w_partial;
    logic                  w_desc_done;

    assign w_pass      = (r_state == IDLE) || (r_state == XFER);
    assign w_accept    = w_pass & bus.in_valid_i & bus.byte_ready_i;
    assign w_desc_done = (r_state == DESC) & bus.desc_ready_i;
    // A flush is only needed when the last word is partly filled; a full word is already out.
    assign w_partial   = (w_len_inc % LenWidth'(BytesPerWord)) != '0;

    assign bus.byte_valid_o = w_pass & bus.in_valid_i;
    assign bus.byte_data_o  = bus.in_data_i;
    assign bus.in_ready_o   = w_pass & bus.byte_ready_i;
    assign bus.flush_o      = (r_state == FLUSH);
    assign bus.desc_valid_o = (r_state == DESC);
    assign bus.desc_data_o  = (r_state == DESC) ? rx_desc_pack(w_ovf, DESC_OVF_BIT'(r_len)) : '0;

`ifdef RX_DESC_OVF_EN
    logic r_ovf;
    logic w_sat;

    assign w_sat     = &r_len;
    assign w_len_inc = w_sat ? r_len : r_len + LenWidth'(1);
    assign w_ovf     = r_ovf;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
        end else if (w_accept && w_sat) begin
            r_ovf <= 1'b1;
        end else if (w_desc_done) begin
            r_ovf <= 1'b0;
        end
    end
`else
    assign w_len_inc = r_len + LenWidth'(1);
    assign w_ovf     = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_len <= '0;
        end else if (w_accept) begin
            r_len <= w_len_inc;
        end else if (w_desc_done) begin
            r_len <= '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, XFER: begin
                if (w_accept) begin
                    if (bus.in_last_i) begin
                        w_state_next = w_partial ? FLUSH : DESC;
                    end else begin
                        w_state_next = XFER;
                    end
                end
            end
            FLUSH:   w_state_next = DESC;
            DESC:    if (bus.desc_ready_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rx_desc_gen.sv
// tb/tb_rx_desc_gen.sv - directed and randomized checks of rx_desc_gen against a byte-count model
module tb_rx_desc_gen;
    import i3c_pkg::*;

    localparam int BPW     = 32 / 8;
    localparam int LEN_MAX = 65535;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    rx_desc_gen_if bus();

    rx_desc_gen #(.Width(32), .LenWidth(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference: descriptor from the number of bytes in the transfer.
    function automatic logic [31:0] model_desc(input int n);
        rx_desc_t d;
        d = '0;
`ifdef RX_DESC_OVF_EN
        d.ovf = (n > LEN_MAX);
        d.len = 16'((n > LEN_MAX) ? LEN_MAX : n);
`else
        d.ovf = 1'b0;
        d.len = 16'(n % (LEN_MAX + 1));
`endif
        return d;
    endfunction

    // mode 0: byte_ready always 1, 1: alternating, 2: random
    task automatic run_xfer(input string name, input int n, input int mode, input int desc_wait);
        int          sent;
        int          cyc;
        bit          acc;
        bit          exp_flush;
        logic [7:0]  cur;
        logic [31:0] exp_desc;
        sent = 0;
        cyc  = 0;
        cur  = 8'($urandom);
        bus.in_valid_i = 1'b1;
        while (sent < n && cyc < 4 * n + 64) begin
            bus.in_data_i    = cur;
            bus.in_last_i    = (sent == n - 1);
            bus.byte_ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? ~cyc[0] : 1'($urandom_range(0, 1));
            @(negedge clk);
            chk({name, "_bvalid"}, 32'(bus.byte_valid_o), 32'd1);
            chk({name, "_bdata"},  32'(bus.byte_data_o), 32'(cur));
            chk({name, "_inrdy"},  32'(bus.in_ready_o), 32'(bus.byte_ready_i));
            chk({name, "_flush0"}, 32'(bus.flush_o), 32'd0);
            chk({name, "_dval0"},  32'(bus.desc_valid_o), 32'd0);
            acc = bus.byte_ready_i;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                sent++;
                cur = 8'($urandom);
            end
        end
        chk({name, "_sent"}, 32'(sent), 32'(n));

        exp_desc  = model_desc(n);
        exp_flush = (exp_desc[15:0] % BPW) != 0;
        bus.in_last_i    = 1'b0;
        bus.in_data_i    = cur;
        bus.byte_ready_i = 1'b1;
        @(negedge clk);
        chk({name, "_flush"},  32'(bus.flush_o), 32'(exp_flush));
        chk({name, "_bp_rdy"}, 32'(bus.in_ready_o), 32'd0);
        chk({name, "_bp_val"}, 32'(bus.byte_valid_o), 32'd0);
        if (exp_flush) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, "_flush_end"}, 32'(bus.flush_o), 32'd0);
        end
        chk({name, "_dvalid"}, 32'(bus.desc_valid_o), 32'd1);
        chk({name, "_desc"},   bus.desc_data_o, exp_desc);
        for (int i = 0; i < desc_wait; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, "_hold_desc"}, bus.desc_data_o, exp_desc);
            chk({name, "_hold_rdy"},  32'(bus.in_ready_o), 32'd0);
            chk({name, "_hold_val"},  32'(bus.byte_valid_o), 32'd0);
        end
        bus.desc_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.desc_ready_i = 1'b0;
        bus.in_valid_i   = 1'b0;
        @(negedge clk);
        chk({name, "_dval_clr"}, 32'(bus.desc_valid_o), 32'd0);
        chk({name, "_ddata_clr"}, bus.desc_data_o, 32'd0);
        chk({name, "_inrdy_idle"}, 32'(bus.in_ready_o), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        bus.in_valid_i   = 1'b0;
        bus.in_data_i    = 8'h00;
        bus.in_last_i    = 1'b0;
        bus.byte_ready_i = 1'b1;
        bus.desc_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_bvalid", 32'(bus.byte_valid_o), 32'd0);
        chk("rst_flush",  32'(bus.flush_o), 32'd0);
        chk("rst_dvalid", 32'(bus.desc_valid_o), 32'd0);
        chk("rst_ddata",  bus.desc_data_o, 32'd0);
        chk("rst_inrdy",  32'(bus.in_ready_o), 32'd1);
        @(posedge clk);
        #1;

        run_xfer("four",  4, 0, 0);
        run_xfer("five",  5, 0, 10);
        run_xfer("seven", 7, 1, 2);
        run_xfer("one",   1, 0, 1);
        run_xfer("eight", 8, 2, 0);

        for (int k = 0; k < 6; k++) begin
            run_xfer("rand", int'($urandom_range(1, 12)), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 3)));
        end

        // Abort a transfer with reset after three bytes.
        bus.in_valid_i   = 1'b1;
        bus.in_last_i    = 1'b0;
        bus.byte_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data_i = 8'($urandom);
            @(posedge clk);
            #1;
        end
        bus.in_valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_flush",  32'(bus.flush_o), 32'd0);
            chk("abort_dvalid", 32'(bus.desc_valid_o), 32'd0);
            chk("abort_bvalid", 32'(bus.byte_valid_o), 32'd0);
            @(posedge clk);
            #1;
        end
        run_xfer("after_rst", 2, 0, 0);

        run_xfer("huge", LEN_MAX + 2, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
